// File: rtl/ps2_mouse_tracker.sv
// rtl/ps2_mouse_tracker.sv - PS/2 mouse bring-up, packet receiver and clamped absolute cursor
module ps2_mouse_tracker #(
    parameter int         DEBOUNCE_CYCLES = 186,
    parameter int         WATCHDOG_CYCLES = 19660,
    parameter int         INHIBIT_CYCLES  = 5000,
    parameter logic [7:0] INIT_CMD        = 8'hF4,
    parameter int         MAX_RETRY       = 3,
    parameter int         SCREEN_W        = 640,
    parameter int         SCREEN_H        = 480,
    parameter int         X_BITS          = 10,
    parameter int         Y_BITS          = 10
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire               ps2_clk,
    inout  wire               ps2_data,
    input  logic              recenter,
    output logic              left_button,
    output logic              right_button,
    output logic              middle_button,
    output logic [X_BITS-1:0] cursor_x,
    output logic [Y_BITS-1:0] cursor_y,
    output logic              update,
    output logic              ready,
    output logic              parity_error,
    output logic              error_no_ack
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    localparam int IN_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int XW   = X_BITS + 2;
    localparam int YW   = Y_BITS + 2;

    localparam logic [2:0] S_INHIBIT  = 3'd0;
    localparam logic [2:0] S_REQ      = 3'd1;
    localparam logic [2:0] S_TX       = 3'd2;
    localparam logic [2:0] S_TX_ACK   = 3'd3;
    localparam logic [2:0] S_WAIT_RSP = 3'd4;
    localparam logic [2:0] S_RUN      = 3'd5;
    localparam logic [2:0] S_ERROR    = 3'd6;

    localparam logic signed [XW-1:0] X_MAX  = XW'(SCREEN_W - 1);
    localparam logic signed [YW-1:0] Y_MAX  = YW'(SCREEN_H - 1);
    localparam logic [X_BITS-1:0]    X_LAST = X_BITS'(SCREEN_W - 1);
    localparam logic [Y_BITS-1:0]    Y_LAST = Y_BITS'(SCREEN_H - 1);
    localparam logic [X_BITS-1:0]    X_CTR  = X_BITS'(SCREEN_W / 2);
    localparam logic [Y_BITS-1:0]    Y_CTR  = Y_BITS'(SCREEN_H / 2);

    logic [1:0]      clk_sync_q, dat_sync_q;
    logic            clk_s, dat_s;
    logic            clk_lvl_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            db_ok, fall, rise, strobe;
    logic [WD_W-1:0] wd_cnt_q;
    logic            wd_expire;

    logic [2:0]      state_q, state_d;
    logic [IN_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      tx_sr_q, tx_sr_d;
    logic [9:0]      rx_sr_q, rx_sr_d;
    logic            data_low_q, data_low_d;
    logic            clk_low_q;
    logic [7:0]      attempt_q, attempt_d;
    logic [1:0]      idx_q, idx_d;
    logic [6:0]      b0_q, b0_d;
    logic [7:0]      b1_q, b1_d;
    logic            commit, retry;

    logic [10:0]     rx_frame;
    logic [7:0]      rx_byte;
    logic            rx_active, rx_done, rx_ok, rx_good, rx_bad;

    logic [2:0]        btn_q;
    logic [X_BITS-1:0] cur_x_q, cx_new;
    logic [Y_BITS-1:0] cur_y_q, cy_new;
    logic              upd_q, perr_q;
    logic signed [XW-1:0] dx, nx;
    logic signed [YW-1:0] dy, ny;

    assign ps2_clk  = clk_low_q  ? 1'b0 : 1'bz;
    assign ps2_data = data_low_q ? 1'b0 : 1'bz;

    assign clk_s  = clk_sync_q[1];
    assign dat_s  = dat_sync_q[1];
    assign db_ok  = db_cnt_q >= DB_W'(DEBOUNCE_CYCLES);
    assign fall   = db_ok && clk_lvl_q && !clk_s;
    assign rise   = db_ok && !clk_lvl_q && clk_s;
    assign strobe = fall || rise;
    assign wd_expire = !strobe && (wd_cnt_q == WD_W'(WATCHDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_lvl_q  <= 1'b1;
            db_cnt_q   <= '0;
            wd_cnt_q   <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            if (strobe) begin
                clk_lvl_q <= clk_s;
                db_cnt_q  <= '0;
                wd_cnt_q  <= '0;
            end else begin
                if (!db_ok)
                    db_cnt_q <= db_cnt_q + 1'b1;
                if (wd_cnt_q != WD_W'(WATCHDOG_CYCLES))
                    wd_cnt_q <= wd_cnt_q + 1'b1;
            end
        end
    end

    // Frame bits arrive LSB first: [0] start, [8:1] data, [9] parity, [10] stop.
    assign rx_frame  = {dat_s, rx_sr_q};
    assign rx_byte   = rx_frame[8:1];
    assign rx_active = (state_q == S_WAIT_RSP) || (state_q == S_RUN);
    assign rx_done   = rx_active && fall && (bit_cnt_q == 4'd10);
    assign rx_ok     = !rx_frame[0] && rx_frame[10] && (^rx_frame[9:1]);
    assign rx_good   = rx_done && rx_ok;
    assign rx_bad    = rx_done && !rx_ok;

    always_comb begin
        state_d    = state_q;
        inh_cnt_d  = inh_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        data_low_d = data_low_q;
        attempt_d  = attempt_q;
        idx_d      = idx_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        commit     = 1'b0;
        retry      = 1'b0;

        if (rx_active) begin
            if (fall) begin
                rx_sr_d   = rx_frame[10:1];
                bit_cnt_d = (bit_cnt_q == 4'd10) ? 4'd0 : bit_cnt_q + 4'd1;
            end else if (wd_expire) begin
                bit_cnt_d = 4'd0;
            end
        end

        case (state_q)
            S_INHIBIT: begin
                if (inh_cnt_q == IN_W'(INHIBIT_CYCLES)) begin
                    state_d    = S_REQ;
                    tx_sr_d    = {1'b1, ~^INIT_CMD, INIT_CMD};
                    data_low_d = 1'b1;
                    bit_cnt_d  = 4'd0;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            S_REQ: state_d = S_TX;
            S_TX: begin
                if (fall) begin
                    data_low_d = !tx_sr_q[0];
                    tx_sr_d    = {1'b1, tx_sr_q[9:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9)
                        state_d = S_TX_ACK;
                end else if (wd_expire) begin
                    retry = 1'b1;
                end
            end
            S_TX_ACK: begin
                if (fall) begin
                    if (!dat_s) begin
                        state_d   = S_WAIT_RSP;
                        bit_cnt_d = 4'd0;
                    end else begin
                        retry = 1'b1;
                    end
                end else if (wd_expire) begin
                    retry = 1'b1;
                end
            end
            S_WAIT_RSP: begin
                if (rx_good && rx_byte == 8'hFA)
                    state_d = S_RUN;
                else if (rx_done || wd_expire)
                    retry = 1'b1;
            end
            S_RUN: begin
                if (rx_bad || wd_expire) begin
                    idx_d = 2'd0;
                end else if (rx_good) begin
                    case (idx_q)
                        2'd0: if (rx_byte[3]) begin
                            b0_d  = {rx_byte[7:4], rx_byte[2:0]};
                            idx_d = 2'd1;
                        end
                        2'd1: begin
                            b1_d  = rx_byte;
                            idx_d = 2'd2;
                        end
                        default: begin
                            idx_d  = 2'd0;
                            commit = 1'b1;
                        end
                    endcase
                end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_INHIBIT;
        endcase

        if (retry) begin
            data_low_d = 1'b0;
            if (attempt_q + 8'd1 < 8'(MAX_RETRY)) begin
                state_d   = S_INHIBIT;
                inh_cnt_d = '0;
                attempt_d = attempt_q + 8'd1;
            end else begin
                state_d = S_ERROR;
            end
        end
    end

    // b0_q keeps byte0 without its always-one bit 3: {ovf_y, ovf_x, sgn_y, sgn_x, buttons}.
    always_comb begin
        dx = b0_q[5] ? '0 : {{(XW - 8){b0_q[3]}}, b1_q};
        dy = b0_q[6] ? '0 : {{(YW - 8){b0_q[4]}}, rx_byte};
        nx = $signed({2'b00, cur_x_q}) + dx;
        ny = $signed({2'b00, cur_y_q}) - dy;
        cx_new = nx[XW-1] ? '0 : (nx > X_MAX) ? X_LAST : nx[X_BITS-1:0];
        cy_new = ny[YW-1] ? '0 : (ny > Y_MAX) ? Y_LAST : ny[Y_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_INHIBIT;
            inh_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            data_low_q <= 1'b0;
            clk_low_q  <= 1'b0;
            attempt_q  <= '0;
            idx_q      <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            btn_q      <= '0;
            cur_x_q    <= X_CTR;
            cur_y_q    <= Y_CTR;
            upd_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inh_cnt_q  <= inh_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            data_low_q <= data_low_d;
            clk_low_q  <= (state_d == S_INHIBIT);
            attempt_q  <= attempt_d;
            idx_q      <= idx_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            upd_q      <= commit || recenter;
            perr_q     <= rx_bad;
            if (commit)
                btn_q <= b0_q[2:0];
            if (recenter) begin
                cur_x_q <= X_CTR;
                cur_y_q <= Y_CTR;
            end else if (commit) begin
                cur_x_q <= cx_new;
                cur_y_q <= cy_new;
            end
        end
    end

    assign left_button   = btn_q[0];
    assign right_button  = btn_q[1];
    assign middle_button = btn_q[2];
    assign cursor_x      = cur_x_q;
    assign cursor_y      = cur_y_q;
    assign update        = upd_q;
    assign parity_error  = perr_q;
    assign ready         = (state_q == S_RUN);
    assign error_no_ack  = (state_q == S_ERROR);
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// tb/tb_ps2_mouse_tracker.sv - directed bench with an open-drain PS/2 mouse model
module tb_ps2_mouse_tracker;
    localparam int HALF = 10;
    localparam int INH  = 50;
    localparam int WD   = 300;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic recenter = 1'b0;
    logic m_clk_low = 1'b0;
    logic m_data_low = 1'b0;
    wire  ps2_clk_w, ps2_data_w;
    logic left_button, right_button, middle_button;
    logic [9:0] cursor_x, cursor_y;
    logic update, ready, parity_error, error_no_ack;

    pullup (ps2_clk_w);
    pullup (ps2_data_w);
    assign ps2_clk_w  = m_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data_w = m_data_low ? 1'b0 : 1'bz;

    ps2_mouse_tracker #(
        .DEBOUNCE_CYCLES(4), .WATCHDOG_CYCLES(WD), .INHIBIT_CYCLES(INH),
        .INIT_CMD(8'hF4), .MAX_RETRY(3), .SCREEN_W(640), .SCREEN_H(480),
        .X_BITS(10), .Y_BITS(10)
    ) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk_w), .ps2_data(ps2_data_w),
        .recenter(recenter), .left_button(left_button), .right_button(right_button),
        .middle_button(middle_button), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .update(update), .ready(ready), .parity_error(parity_error),
        .error_no_ack(error_no_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int upd_cnt = 0;
    int perr_cnt = 0;
    int inh_cnt = 0;
    logic clk_line_prev = 1'b1;

    always @(negedge clk) begin
        if (update === 1'b1) upd_cnt++;
        if (parity_error === 1'b1) perr_cnt++;
    end

    always @(posedge clk) begin
        if (clk_line_prev === 1'b1 && ps2_clk_w === 1'b0) inh_cnt++;
        clk_line_prev <= ps2_clk_w;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic rc);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            m_data_low = !f[i];
            tick(HALF);
            m_clk_low = 1'b1;
            if (rc && i == 10) begin
                tick(2);
                recenter = 1'b1;
                tick(1);
                recenter = 1'b0;
                tick(HALF - 3);
            end else begin
                tick(HALF);
            end
            m_clk_low = 1'b0;
        end
        m_data_low = 1'b0;
        tick(2 * HALF);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic rc);
        send_byte(b0, 1'b0, 1'b0);
        send_byte(b1, 1'b0, 1'b0);
        send_byte(b2, 1'b0, rc);
    endtask

    task automatic accept_cmd(output logic [9:0] bits, output int low_len,
                              output logic req_dat, output bit ok);
        int t;
        t = 0;
        ok = 1'b1;
        bits = '0;
        req_dat = 1'b1;
        low_len = 0;
        while (ps2_clk_w !== 1'b0 && t < 5000) begin
            tick(1);
            t++;
        end
        if (t >= 5000) begin
            ok = 1'b0;
            return;
        end
        while (ps2_clk_w === 1'b0 && low_len < 5000) begin
            tick(1);
            low_len++;
        end
        tick(HALF);
        req_dat = ps2_data_w;
        for (int i = 0; i < 10; i++) begin
            m_clk_low = 1'b1;
            tick(HALF);
            m_clk_low = 1'b0;
            bits[i] = ps2_data_w;
            tick(HALF);
        end
        m_data_low = 1'b1;
        tick(HALF);
        m_clk_low = 1'b1;
        tick(HALF);
        m_clk_low = 1'b0;
        tick(HALF);
        m_data_low = 1'b0;
        tick(2 * HALF);
    endtask

    initial begin
        logic [9:0] bits;
        int low_len, u0, p0, c0, t;
        logic req_dat;
        bit ok;

        tick(5);
        check_eq("rst_left", left_button, 0);
        check_eq("rst_right", right_button, 0);
        check_eq("rst_middle", middle_button, 0);
        check_eq("rst_x", cursor_x, 320);
        check_eq("rst_y", cursor_y, 240);
        check_eq("rst_update", update, 0);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_perr", parity_error, 0);
        check_eq("rst_noack", error_no_ack, 0);
        check_eq("rst_clk_z", ps2_clk_w, 1);
        check_eq("rst_dat_z", ps2_data_w, 1);
        reset = 1'b0;

        accept_cmd(bits, low_len, req_dat, ok);
        check_eq("init_request_seen", ok, 1);
        check_eq("init_inhibit_len", low_len >= INH, 1);
        check_eq("init_req_data_low", req_dat, 0);
        check_eq("init_cmd", bits[7:0], 8'hF4);
        check_eq("init_parity", bits[8], 0);
        check_eq("init_stop", bits[9], 1);
        send_byte(8'hFA, 1'b0, 1'b0);
        check_eq("init_ready", ready, 1);
        check_eq("init_noack", error_no_ack, 0);

        u0 = upd_cnt;
        send_pkt(8'h09, 8'h05, 8'h03, 1'b0);
        check_eq("mot_updates", upd_cnt - u0, 1);
        check_eq("mot_left", left_button, 1);
        check_eq("mot_right", right_button, 0);
        check_eq("mot_middle", middle_button, 0);
        check_eq("mot_x", cursor_x, 325);
        check_eq("mot_y", cursor_y, 237);

        for (int k = 1; k <= 20; k++) begin
            send_pkt(8'h18, 8'hE0, 8'h00, 1'b0);
            check_eq("neg_x", cursor_x, (325 - 32 * k) < 0 ? 0 : 325 - 32 * k);
        end
        check_eq("neg_y", cursor_y, 237);
        check_eq("neg_left", left_button, 0);

        for (int k = 1; k <= 7; k++) begin
            send_pkt(8'h08, 8'h7F, 8'h00, 1'b0);
            check_eq("pos_x", cursor_x, (127 * k) > 639 ? 639 : 127 * k);
        end
        check_eq("pos_y", cursor_y, 237);

        u0 = upd_cnt;
        p0 = perr_cnt;
        send_byte(8'h08, 1'b0, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        check_eq("par_pulses", perr_cnt - p0, 1);
        check_eq("par_no_update", upd_cnt - u0, 0);
        send_pkt(8'h18, 8'h9C, 8'h0A, 1'b0);
        check_eq("par_next_updates", upd_cnt - u0, 1);
        check_eq("par_next_x", cursor_x, 539);
        check_eq("par_next_y", cursor_y, 227);

        send_pkt(8'h48, 8'hFF, 8'h10, 1'b0);
        check_eq("ovf_x", cursor_x, 539);
        check_eq("ovf_y", cursor_y, 211);

        u0 = upd_cnt;
        send_byte(8'h00, 1'b0, 1'b0);
        send_pkt(8'h09, 8'h05, 8'h03, 1'b0);
        check_eq("sync_updates", upd_cnt - u0, 1);
        check_eq("sync_x", cursor_x, 544);
        check_eq("sync_y", cursor_y, 208);
        check_eq("sync_left", left_button, 1);

        u0 = upd_cnt;
        send_byte(8'h08, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        tick(WD + 100);
        check_eq("frag_no_update", upd_cnt - u0, 0);
        send_pkt(8'h08, 8'h02, 8'h00, 1'b0);
        check_eq("frag_next_updates", upd_cnt - u0, 1);
        check_eq("frag_next_x", cursor_x, 546);
        check_eq("frag_next_y", cursor_y, 208);
        check_eq("frag_next_left", left_button, 0);

        u0 = upd_cnt;
        send_pkt(8'h0E, 8'h10, 8'h10, 1'b1);
        check_eq("rc_updates", upd_cnt - u0, 1);
        check_eq("rc_x", cursor_x, 320);
        check_eq("rc_y", cursor_y, 240);
        check_eq("rc_left", left_button, 0);
        check_eq("rc_right", right_button, 1);
        check_eq("rc_middle", middle_button, 1);

        reset = 1'b1;
        tick(3);
        check_eq("na_ready_reset", ready, 0);
        reset = 1'b0;
        c0 = inh_cnt;
        t = 0;
        while (error_no_ack !== 1'b1 && t < 5000) begin
            tick(1);
            t++;
        end
        check_eq("na_error_in_time", t < 5000, 1);
        tick(1000);
        check_eq("na_attempts", inh_cnt - c0, 3);
        check_eq("na_error_sticky", error_no_ack, 1);
        check_eq("na_ready", ready, 0);
        check_eq("na_clk_z", ps2_clk_w, 1);
        check_eq("na_dat_z", ps2_data_w, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ps2_mouse_tracker.md
Name: ps2_mouse_tracker

Overview:
Next-generation PS/2 mouse front end for the paint datapath.
- Brings the mouse up autonomously: inhibit, send Enable Data Reporting (0xF4), check the ack byte 0xFA, retry on failure.
- Receives and checks 3-byte movement packets.
- Keeps an absolute cursor position clamped to a parametrised screen, so pixel logic reads coordinates directly instead of increments.

Parameters:
DEBOUNCE_CYCLES, 186, clk cycles ps2_clk must be stable after an edge before the next edge is accepted
WATCHDOG_CYCLES, 19660, idle clk cycles (~400 us) that abort a partial byte or packet, or an unacknowledged transmission
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before a host-to-device request (>=100 us)
INIT_CMD, 8'hF4, command byte sent after reset
MAX_RETRY, 3, init attempts before declaring error
SCREEN_W, 640, horizontal extent in pixels
SCREEN_H, 480, vertical extent in pixels
X_BITS, 10, cursor_x width (2^X_BITS >= SCREEN_W)
Y_BITS, 10, cursor_y width

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high
ps2_clk  inout  1  open-drain; drive 0 or Z only
ps2_data  inout  1  open-drain; drive 0 or Z only
recenter  in  1  pulse: move cursor to centre
left_button  out  1  latest packet byte0[0]
right_button  out  1  byte0[1]
middle_button  out  1  byte0[2]
cursor_x  out  X_BITS  absolute X, 0..SCREEN_W-1
cursor_y  out  Y_BITS  absolute Y, 0..SCREEN_H-1, 0 = top
update  out  1  one-cycle pulse when buttons/cursor change
ready  out  1  high once init ack received (state RUN)
parity_error  out  1  one-cycle pulse per rejected received byte
error_no_ack  out  1  sticky until reset; init failed

Behaviour:
Reset values:
- buttons = 0; cursor_x = SCREEN_W/2, cursor_y = SCREEN_H/2.
- update, ready, parity_error, error_no_ack = 0.
- Both lines Z; controller FSM in INHIBIT.
- reset mid-transfer aborts everything and restarts init on the next cycle.

Edge detector:
- Debounced ps2_clk; fall/rise strobes are one cycle wide.
- After a strobe, the opposite edge is ignored until DEBOUNCE_CYCLES elapse.
- The watchdog counter clears on any strobe and saturates at WATCHDOG_CYCLES.

Controller FSM:
- INHIBIT: ps2_clk driven low for INHIBIT_CYCLES -> REQ.
- REQ: ps2_data driven low, ps2_clk released -> TX.
- TX: on each fall, present the next bit: INIT_CMD LSB-first, then odd parity, then release (stop). After 10 falls -> TX_ACK.
- TX_ACK: on the next fall, ps2_data==0 -> WAIT_RSP; ps2_data==1 -> retry.
- WAIT_RSP: first valid received byte == 8'hFA -> RUN (ready=1). Any other byte, a parity error, or watchdog expiry -> retry.
- Retry: increment the attempt count. If count < MAX_RETRY -> INHIBIT, else -> ERROR.
- Watchdog expiry in TX or TX_ACK also counts as a retry.
- ERROR: error_no_ack=1, lines Z, stays until reset.
- RUN: receive only.

Byte receiver (active in WAIT_RSP and RUN):
- Sample ps2_data on each fall into an 11-bit shift register.
- After the 11th bit: valid if start==0, stop==1 and XOR(data,parity)==1. Otherwise pulse parity_error and discard.
- Watchdog expiry with 1..10 bits collected discards the partial byte silently.

Packet assembler (RUN only):
- Byte index 0..2.
- Byte0 with bit3==0 is discarded; index stays 0 (resync).
- A parity error or watchdog expiry with index != 0 resets the index to 0 and drops the packet.

Arithmetic, on the third byte:
- dx = signed {b0[4],b1}; dy = signed {b0[5],b2} (9-bit two's complement).
- b0[6]=1 forces dx=0; b0[7]=1 forces dy=0.
- nx = cursor_x + dx; ny = cursor_y - dy (screen Y grows downward).
- Compute in X_BITS+2 / Y_BITS+2 signed width, then clamp to [0, SCREEN_W-1] and [0, SCREEN_H-1].

Output timing:
- Buttons, cursor and update are registered in the cycle after the third byte's stop bit is sampled.
- update pulses even when the position is unchanged.
- recenter loads the centre position and pulses update.
- recenter in the same cycle as a packet commit: centre wins for the cursor; buttons still take the packet values; a single update pulse.

Test Plan:
- Init: mouse model acks INIT_CMD 0xF4 (bits 0,0,1,0,1,1,1,1, parity 0) and returns 0xFA -> ready=1, no error_no_ack, ps2_clk held low >= INHIBIT_CYCLES.
- Motion: packet 0x09,0x05,0x03 after init -> left_button=1, cursor (325,237), one update pulse.
- Negative and clamp: 20 packets 0x18,0xE0,0x00 (dx=-32) -> cursor_x saturates at 0, never wraps. Then 0x08,0x7F,0x00 repeated -> saturates at 639.
- Error handling, parity and overflow: corrupt the parity of byte1 -> parity_error pulse, no update, next clean packet accepted. Packet 0x48,0xFF,0x10 -> x unchanged, y decreases by 16.
- Resync: byte stream 0x00,0x09,0x05,0x03 -> leading 0x00 discarded, one update with dx=5. Then a 2-byte fragment plus a watchdog idle -> dropped.
- No ack and recenter: mouse never acks -> exactly 3 inhibit/request attempts, then error_no_ack stays 1. Separately, recenter coincident with a packet commit -> cursor (320,240), buttons from the packet.
